// File: rtl/reflet_byte_bridge.sv
// Reflet CPU memory port to byte-wide synchronous RAM: each word access becomes
// a little-endian burst of wordsize/8 byte transfers, with the CPU stalled until done.
module reflet_byte_bridge #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    input  logic                cpu_write_en,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_enable,
    output logic [wordsize-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    output logic                mem_write_en
);
    localparam int N  = wordsize / 8;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD      = 2'd1;
    localparam logic [1:0] RD_LAST = 2'd2;
    localparam logic [1:0] WR      = 2'd3;

    logic [1:0]          state;
    logic [KW-1:0]       k;
    logic [wordsize-1:0] req_addr;
    logic [N-1:0][7:0]   req_wdata;
    logic [wordsize-1:0] tag_addr;
    logic [wordsize-1:0] tag_wdata;
    logic                tag_we;
    logic                tag_valid;
    logic [N-1:0][7:0]   rbuf;
    logic [N-1:0][7:0]   rword;
    logic                new_req;

    // A write is only re-issued when its data differs; reads ignore cpu_wdata.
    assign new_req = (state == IDLE) &&
                     (!tag_valid || (cpu_addr != tag_addr) || (cpu_write_en != tag_we) ||
                      (cpu_write_en && (cpu_wdata != tag_wdata)));
    assign cpu_enable = (state == IDLE) && !new_req;

    always_comb begin
        mem_addr     = tag_addr;
        mem_wdata    = '0;
        mem_write_en = 1'b0;
        case (state)
            RD, RD_LAST: mem_addr = req_addr + wordsize'(k);
            WR: begin
                mem_addr     = req_addr + wordsize'(k);
                mem_wdata    = req_wdata[k];
                mem_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Last byte arrives in RD_LAST straight from the RAM, so merge it in here.
    always_comb begin
        rword        = rbuf;
        rword[N-1]   = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            tag_addr  <= '0;
            tag_wdata <= '0;
            tag_we    <= 1'b0;
            tag_valid <= 1'b0;
            rbuf      <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_req) begin
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        k         <= '0;
                        state     <= cpu_write_en ? WR : RD;
                    end
                end
                RD: begin
                    // mem_rdata lags mem_addr by one cycle, hence byte k-1.
                    if (k != '0)
                        rbuf[k - KW'(1)] <= mem_rdata;
                    if (k == K_LAST)
                        state <= RD_LAST;
                    else
                        k <= k + KW'(1);
                end
                RD_LAST: begin
                    cpu_rdata <= rword;
                    tag_addr  <= req_addr;
                    tag_wdata <= req_wdata;
                    tag_we    <= 1'b0;
                    tag_valid <= 1'b1;
                    state     <= IDLE;
                end
                WR: begin
                    if (k == K_LAST) begin
                        tag_addr  <= req_addr;
                        tag_wdata <= req_wdata;
                        tag_we    <= 1'b1;
                        tag_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_byte_bridge.sv
// Scoreboard bench for reflet_byte_bridge: 16-bit instance with a byte RAM model,
// plus a 32-bit instance for the wide-word read case.
module tb_reflet_byte_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        reset32;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
    logic        cpu_write_en, cpu_enable, mem_write_en;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [31:0] c32_addr, c32_wdata, c32_rdata, c32_maddr;
    logic        c32_we, c32_en, c32_mwe;
    logic [7:0]  c32_mwdata, c32_mrdata;

    bit [7:0] ram16 [65536];
    bit [7:0] model [65536];
    bit [7:0] ram32 [4096];

    logic [23:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [23:0] wr_e;
    int n_tests = 0;
    int n_fail = 0;
    int spurious = 0;

    always #5 clk = ~clk;

    reflet_byte_bridge #(.wordsize(16)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_write_en(cpu_write_en), .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_write_en(mem_write_en)
    );

    reflet_byte_bridge #(.wordsize(32)) dut32 (
        .clk(clk), .reset(reset32), .cpu_addr(c32_addr), .cpu_wdata(c32_wdata),
        .cpu_write_en(c32_we), .cpu_rdata(c32_rdata), .cpu_enable(c32_en),
        .mem_addr(c32_maddr), .mem_wdata(c32_mwdata), .mem_rdata(c32_mrdata),
        .mem_write_en(c32_mwe)
    );

    always @(posedge clk) begin
        if (mem_write_en) ram16[mem_addr] <= mem_wdata;
        mem_rdata <= ram16[mem_addr];
        if (c32_mwe) ram32[c32_maddr[11:0]] <= c32_mwdata;
        c32_mrdata <= ram32[c32_maddr[11:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every byte strobe must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (mem_write_en === 1'b1) begin
            if (exp_wr.size() == 0) spurious++;
            else begin
                wr_e = exp_wr.pop_front();
                chk("mem_wr", {mem_addr, mem_wdata}, wr_e);
            end
        end
    end

    // Called at a negedge; the remainder of this cycle is the detect cycle.
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic we, input string tag);
        int lows;
        int exp_lows;
        exp_lows = we ? 3 : 4;
        if (we) begin
            exp_wr.push_back({a, d[7:0]});
            exp_wr.push_back({16'(a + 16'd1), d[15:8]});
            model[a] = d[7:0];
            model[16'(a + 16'd1)] = d[15:8];
        end else begin
            exp_rd.push_back({16'h0, model[16'(a + 16'd1)], model[a]});
        end
        cpu_addr = a; cpu_wdata = d; cpu_write_en = we;
        #1;
        lows = cpu_enable ? 0 : 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!we && i <= 2) chk({tag, "_maddr"}, mem_addr, 16'(a + 16'(i - 1)));
            if (cpu_enable) break;
            lows++;
        end
        chk({tag, "_stall"}, lows, exp_lows);
        if (!we) chk({tag, "_rdata"}, {16'h0, cpu_rdata}, exp_rd.pop_front());
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("hold_en", cpu_enable, 1'b1);
        end
    endtask

    initial begin
        logic [15:0] a, d;
        int lows;
        ram16[16'h0010] <= 8'h34; model[16'h0010] = 8'h34;
        ram16[16'h0011] <= 8'h12; model[16'h0011] = 8'h12;
        ram16[16'hFFFF] <= 8'hAB; model[16'hFFFF] = 8'hAB;
        ram16[16'h0000] <= 8'hCD; model[16'h0000] = 8'hCD;
        for (int i = 0; i < 4; i++) ram32[12'h100 + 12'(i)] <= 8'(i + 1);

        reset = 1'b0; reset32 = 1'b0;
        cpu_addr = 16'h0010; cpu_wdata = 16'h0; cpu_write_en = 1'b0;
        c32_addr = 32'h0; c32_wdata = 32'h0; c32_we = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mwe", mem_write_en, 1'b0);
        chk("rst_maddr", mem_addr, 16'h0);
        chk("rst_mwdata", mem_wdata, 8'h0);
        chk("rst_en", cpu_enable, 1'b0);
        chk("rst_rdata", cpu_rdata, 16'h0);

        reset = 1'b1; reset32 = 1'b1;
        access(16'h0010, 16'h0, 1'b0, "rd10");
        hold(3);
        access(16'h0020, 16'hBEEF, 1'b1, "wr20");
        chk("wr20_rdata_kept", cpu_rdata, 16'h1234);
        hold(4);
        access(16'h0020, 16'hBEEF, 1'b0, "rd20");
        access(16'hFFFF, 16'h0, 1'b0, "rdwrap");
        access(16'h0010, 16'h0, 1'b0, "b2b");

        // Reset lands in the second WR cycle; the whole word is rewritten afterwards.
        exp_wr.push_back({16'h0040, 8'hFE});
        exp_wr.push_back({16'h0041, 8'hCA});
        model[16'h0040] = 8'hFE; model[16'h0041] = 8'hCA;
        cpu_addr = 16'h0040; cpu_wdata = 16'hCAFE; cpu_write_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_mwe", mem_write_en, 1'b0);
        chk("mrst_rdata", cpu_rdata, 16'h0);
        chk("mrst_en", cpu_enable, 1'b0);
        reset = 1'b1;
        access(16'h0040, 16'hCAFE, 1'b1, "rewr");
        access(16'h0040, 16'hCAFE, 1'b0, "rd40");

        for (int i = 0; i < 12; i++) begin
            a = 16'h0200 + 16'($urandom_range(0, 254));
            d = 16'($urandom);
            access(a, d, 1'b1, "rnd_wr");
            if (i[0]) a = 16'h0200 + 16'($urandom_range(0, 255));
            access(a, d, 1'b0, "rnd_rd");
        end

        exp_rd.push_back(32'h04030201);
        c32_addr = 32'h100;
        #1;
        lows = c32_en ? 0 : 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i <= 4) chk("w32_maddr", c32_maddr, 32'h100 + 32'(i - 1));
            if (c32_en) break;
            lows++;
        end
        chk("w32_stall", lows, 6);
        chk("w32_rdata", c32_rdata, exp_rd.pop_front());

        hold(2);
        chk("wr_pending", exp_wr.size(), 0);
        chk("spurious_wr", spurious, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reflet_byte_bridge.md
# reflet_byte_bridge

Responder-side bridge between the Reflet CPU memory port and an 8-bit-wide synchronous RAM. It serves each word-wide CPU access as a burst of `wordsize/8` byte transfers in little-endian order. It stalls the CPU through its `enable` input until the assembled word is stable. It sits between the CPU's `addr`/`data_out`/`data_in`/`write_en` pins and a byte memory or byte-wide external bus.

## Interface
- `wordsize`, 16: CPU word and address width; must be a multiple of 8 and ≥ 8; N = wordsize/8 bytes per access.

Ports (`cpu_*` = CPU side, `mem_*` = RAM side):
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `cpu_addr` input wordsize: byte address of the CPU access (CPU `addr`).
- `cpu_wdata` input wordsize: write data (CPU `data_out`).
- `cpu_write_en` input 1: access is a write.
- `cpu_rdata` output wordsize: assembled read word (to CPU `data_in`); registered.
- `cpu_enable` output 1: to CPU `enable`; low = CPU stalled.
- `mem_addr` output wordsize: byte address to RAM.
- `mem_wdata` output 8: byte to write.
- `mem_rdata` input 8: byte read; valid one cycle after `mem_addr` is presented (synchronous RAM).
- `mem_write_en` output 1: byte write strobe.

## Operation
- Request tag: registers `tag_addr`, `tag_we`, `tag_wdata` and flag `tag_valid`. These hold the last completed access.
- A request is **new** when the FSM is in IDLE and any of the following holds:
  - `tag_valid` = 0;
  - `cpu_addr` ≠ `tag_addr`;
  - `cpu_write_en` ≠ `tag_we`;
  - `cpu_write_en` = 1 and `cpu_wdata` ≠ `tag_wdata`.
- `cpu_enable` = (state == IDLE) && !new. The signal is combinational and low in the detect cycle itself.
- States:
  - IDLE: on new, latch the request into `req_*`, clear `k`, go to RD if read or WR if write.
  - RD: `mem_addr` = req_addr + k, `mem_write_en` = 0. Each cycle with k ≥ 1, store `mem_rdata` into byte k-1 of the shift buffer. After k = N-1 is issued, go to RD_LAST.
  - RD_LAST: store byte N-1, load the full buffer into `cpu_rdata`, update the tag and set `tag_valid`, go to IDLE.
  - WR: `mem_addr` = req_addr + k, `mem_wdata` = req_wdata[8k+7:8k], `mem_write_en` = 1. After k = N-1, update the tag (`cpu_rdata` unchanged), go to IDLE.
- Byte order: byte k of the word is at address base + k (little-endian). Address arithmetic is modulo 2^wordsize, so it wraps past all-ones.
- The request is taken from the `req_*` latches, never from live `cpu_*` pins. CPU-side changes during a burst do not affect it and are evaluated in the next IDLE cycle.
- A write with an unchanged tag while IDLE is not repeated. A subsequent read of the same address is a new request (`tag_we` differs) and re-reads the RAM. There is no forwarding.
- In IDLE, `mem_addr` = `tag_addr`, `mem_write_en` = 0, `mem_wdata` = 0.
- N = 1 (wordsize 8): RD lasts one cycle and WR lasts one cycle; otherwise the behaviour is identical.

## Timing
- Reset (`reset` = 0 at an edge): state IDLE, `tag_valid` = 0, `tag_*` = 0, `cpu_rdata` = 0, k = 0. Outputs after reset:
  - `mem_write_en` = 0, `mem_addr` = 0, `mem_wdata` = 0;
  - `cpu_enable` = 0, because the first cycle out of reset always detects a new request.
- Read: the detect cycle (D) is followed by N RD cycles and 1 RD_LAST cycle. `cpu_rdata` updates at the end of RD_LAST. `cpu_enable` is low for N+2 cycles (D through RD_LAST) and returns high in the following cycle.
- Write: D is followed by N WR cycles, with `mem_write_en` high for exactly N cycles. `cpu_enable` is low for N+1 cycles.
- Reset mid-burst takes priority. `mem_write_en` is 0 from the next cycle, and a partially written word is left partial. `tag_valid` is cleared, so the access is re-run after reset.
- Back-to-back requests: a new request can be detected in the first IDLE cycle after a burst, so there is no bubble beyond the detect cycle.

## Test plan
- Reset, then hold `cpu_addr` = 0x0010 read; RAM holds [0x10] = 0x34 and [0x11] = 0x12. Required:
  - `cpu_enable` low 4 cycles;
  - `mem_addr` sequence 0x0010, 0x0011;
  - `cpu_rdata` = 0x1234, then `cpu_enable` high and stays high while the input is stable.
- Write 0xBEEF to 0x0020. Required:
  - two `mem_write_en` cycles: (0x0020, 0xEF), (0x0021, 0xBE);
  - `cpu_enable` low 3 cycles;
  - no further writes while `cpu_*` is held.
- Write to 0x0020, then drop `cpu_write_en` with the same address. Required: a new read burst and `cpu_rdata` = 0xBEEF.
- Read at 0xFFFF. Required: `mem_addr` 0xFFFF then 0x0000; bytes are assembled in that order.
- `reset` low during the second WR cycle. Required:
  - `mem_write_en` = 0 on the next cycle;
  - `cpu_rdata` = 0, `cpu_enable` = 0;
  - the write is re-issued in full after reset is released.
- wordsize = 32, read at 0x100 with bytes 0x01..0x04. Required: `cpu_rdata` = 0x04030201 and `cpu_enable` low 6 cycles.
